vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single VGA plot port (VGA_X/VGA_Y/VGA_COLOR/plot) between three pixel-stream requesters: start-screen drawer, screen resetter and note-block drawer.
- Also contains a built-in clear-screen sequencer that sweeps the whole 160x120 frame in one colour.
- Sits between the drawing modules and the VGA adapter in the top level, replacing ad-hoc per-state muxing of the plot signals.

Parameters:
- NREQ, 3, number of pixel-stream requesters.
- SCREEN_W, 160, frame width in pixels.
- SCREEN_H, 120, frame height in pixels.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous reset, active-high (despite the name).
- req  in  NREQ  per-requester burst request.
- px_valid  in  NREQ  per-requester pixel valid.
- px_last  in  NREQ  marks the final pixel of a burst.
- px_x  in  8*NREQ  packed x coordinates; requester i occupies [8i+7:8i].
- px_y  in  7*NREQ  packed y coordinates.
- px_colour  in  24*NREQ  packed 24-bit RGB.
- px_ready  out  NREQ  pixel accepted this cycle.
- grant  out  NREQ  one-hot current owner.
- clear_start  in  1  single-cycle pulse that requests a full-screen clear.
- clear_colour  in  24  fill colour, sampled when the clear begins.
- clear_busy  out  1  high while the clear is pending or running.
- VGA_X  out  8  plot x.
- VGA_Y  out  7  plot y.
- VGA_COLOR  out  24  plot colour.
- plot  out  1  write enable to the VGA adapter.

Behaviour:
- Reset (async, resetn=1):
  - state=ARB; grant=0; px_ready=0; clear_busy=0; plot=0.
  - VGA_X=0, VGA_Y=0, VGA_COLOR=0.
  - Clear-pending flag=0; round-robin pointer=0.
  - Reset mid-burst or mid-clear aborts immediately. No further plot occurs.
- States:
  - ARB:
    - If the clear-pending flag is set: go to CLEAR, load x=0, y=0, latch clear_colour.
    - Else if any req is set: grant the first requester with req=1, searching round-robin from the pointer. Go to GRANT.
    - Else stay in ARB.
  - GRANT:
    - px_ready[g]=1 for the owner only; all other bits are 0. The VGA path never back-pressures.
    - A beat is accepted when px_valid[g]=1.
    - On acceptance of a beat with px_last[g]=1: go to ARB; set pointer = g+1 mod NREQ.
    - If req[g] deasserts without last: abort to ARB, same pointer update, no plot that cycle.
  - CLEAR:
    - Emits one pixel per cycle in raster order (x fastest).
    - After x=SCREEN_W-1, y=SCREEN_H-1 is emitted, go to ARB.
    - Total 19200 plot cycles; not preemptible by req.
- Arbitration:
  - Clear has priority over every requester at arbitration time only. Bursts are never preempted.
  - Grant changes only in ARB, so there is one dead cycle (grant=0) between consecutive owners.
  - grant is registered: it is high from the cycle after the ARB decision.
- Output pipeline:
  - One-cycle latency. A beat accepted in cycle N, or a clear pixel generated in cycle N, appears on VGA_X/VGA_Y/VGA_COLOR with plot=1 in cycle N+1.
  - plot=0 in every other cycle. VGA_* hold their last value while plot=0.
- Bounds: an accepted beat with x>=SCREEN_W or y>=SCREEN_H is consumed (px_ready=1), but plot=0 for it.
- Clear handshake:
  - A clear_start pulse sets the clear-pending flag, and clear_busy=1 from the next cycle.
  - clear_busy drops in the cycle after the last clear pixel is plotted.
  - clear_start while clear_busy=1 is ignored; multiple clears are not queued.
  - If clear_start and the ARB decision fall on the same cycle, the decision made that cycle stands; the clear is taken at the next ARB.
- Round-robin pointer: advances only on release of a requester grant. A clear does not move it.

Test Plan:
- Single burst: req[1]=1 with 4 valid beats (x=10..13, y=5, colour=24'hFF0000), last on the 4th.
  - grant=3'b010 one cycle after req.
  - plot=1 on 4 consecutive cycles with VGA_X=10,11,12,13, each one cycle after acceptance.
  - grant=0 after the last beat.
- Contention: req[0] and req[2] held continuously, 2-beat bursts, pointer=0.
  - Grant order is 0, 2, 0, 2, with exactly one grant=0 cycle between owners.
  - No plot occurs from the non-owner.
- Clear during burst: clear_start pulsed mid-burst of requester 0, clear_colour=24'h00FF00.
  - The burst completes.
  - Next ARB enters CLEAR: first plot is (0,0) green, last is (159,119).
  - Exactly 19200 plot cycles; clear_busy falls one cycle after the last plot.
  - A second clear_start pulsed during the clear has no effect.
- Out of bounds: beat with x=200, y=3.
  - px_ready=1, plot=0 for that beat.
  - The next in-range beat plots normally.
- Abort: owner drops req after 2 of 5 beats, no last.
  - Grant releases; only 2 plots occur.
  - The next requester is granted by round-robin.
- Reset: resetn asserted mid-clear at pixel (40,7).
  - plot, grant, clear_busy and VGA_* are 0 immediately (asynchronously).
  - After release, state=ARB and no plot occurs until a new request.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single VGA plot port between NREQ pixel-stream
// requesters (round-robin, whole bursts) and a built-in full-frame clear
// sequencer. Every plotted pixel leaves through one register stage.
module vga_plot_arbiter #(
  parameter int NREQ     = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,      // active-high asynchronous reset
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      px_valid,
  input  logic [NREQ-1:0]      px_last,
  input  logic [8*NREQ-1:0]    px_x,
  input  logic [7*NREQ-1:0]    px_y,
  input  logic [24*NREQ-1:0]   px_colour,
  output logic [NREQ-1:0]      px_ready,
  output logic [NREQ-1:0]      grant,
  input  logic                 clear_start,
  input  logic [23:0]          clear_colour,
  output logic                 clear_busy,
  output logic [7:0]           VGA_X,
  output logic [6:0]           VGA_Y,
  output logic [23:0]          VGA_COLOR,
  output logic                 plot
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   own_q, own_d;     // index of the current owner
  logic [IDXW-1:0]   ptr_q, ptr_d;     // round-robin search start
  logic              pend_q, pend_d;   // clear requested, not yet started
  logic              busy_q, busy_d;
  logic [7:0]        cx_q, cx_d;       // clear raster position
  logic [6:0]        cy_q, cy_d;
  logic [23:0]       ccol_q, ccol_d;   // fill colour latched at clear start
  logic [7:0]        vx_q, vx_d;       // output stage
  logic [6:0]        vy_q, vy_d;
  logic [23:0]       vc_q, vc_d;
  logic              plot_q, plot_d;

  // Round-robin search and owner lane selection
  logic              rr_found;
  logic [IDXW-1:0]   rr_idx;
  logic [IDXW-1:0]   cand_idx;
  int                cand;
  int                own_i;
  logic [7:0]        own_x;
  logic [6:0]        own_y;
  logic [23:0]       own_c;
  logic              own_req;
  logic              own_valid;
  logic              own_last;
  logic              own_inb;
  logic [IDXW-1:0]   ptr_next;
  logic              clr_last;

  assign own_i     = int'(own_q);
  assign own_x     = px_x[own_i*8 +: 8];
  assign own_y     = px_y[own_i*7 +: 7];
  assign own_c     = px_colour[own_i*24 +: 24];
  assign own_req   = req[own_q];
  assign own_valid = px_valid[own_q];
  assign own_last  = px_last[own_q];
  assign own_inb   = (own_x < 8'(SCREEN_W)) && (own_y < 7'(SCREEN_H));
  // Pointer moves to the requester after the one that just released.
  assign ptr_next  = (own_q == IDXW'(NREQ-1)) ? '0 : own_q + 1'b1;

  // First requesting index found when searching upward from the pointer
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = cand[IDXW-1:0];
      if (!rr_found && req[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Next-state, grant, clear sequencing and output-stage loads
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    own_d    = own_q;
    ptr_d    = ptr_q;
    pend_d   = pend_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    ccol_d   = ccol_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    vc_d     = vc_q;
    plot_d   = 1'b0;
    clr_last = 1'b0;

    // A clear request while one is pending or running is dropped.
    if (clear_start && !busy_q) pend_d = 1'b1;

    case (state_q)
      ARB: begin
        if (pend_q) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
          cx_d    = '0;
          cy_d    = '0;
          ccol_d  = clear_colour;
        end else if (rr_found) begin
          state_d = GRANT;
          own_d   = rr_idx;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << rr_idx;
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Owner gave up mid-burst: release without plotting.
          state_d = ARB;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (own_valid) begin
          if (own_inb) begin
            plot_d = 1'b1;
            vx_d   = own_x;
            vy_d   = own_y;
            vc_d   = own_c;
          end
          if (own_last) begin
            state_d = ARB;
            grant_d = '0;
            ptr_d   = ptr_next;
          end
        end
      end
      CLEAR: begin
        plot_d = 1'b1;
        vx_d   = cx_q;
        vy_d   = cy_q;
        vc_d   = ccol_q;
        if (cx_q == 8'(SCREEN_W-1)) begin
          cx_d = '0;
          if (cy_q == 7'(SCREEN_H-1)) begin
            state_d  = ARB;
            clr_last = 1'b1;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB;
        grant_d = '0;
      end
    endcase

    // Busy covers the pending wait, the sweep and the final pixel's plot cycle.
    busy_d = pend_d || (state_d == CLEAR) || clr_last;
  end

  // State and datapath registers, all cleared by reset
  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      state_q <= ARB;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      ccol_q  <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ccol_q  <= ccol_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
    end
  end

  // The VGA path never stalls, so the owner is ready for its whole burst.
  assign px_ready   = (state_q == GRANT) ? grant_q : '0;
  assign grant      = grant_q;
  assign clear_busy = busy_q;
  assign VGA_X      = vx_q;
  assign VGA_Y      = vy_q;
  assign VGA_COLOR  = vc_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: expected pixels are queued as stimulus is driven
// and popped by a monitor whenever plot is high.
module tb_vga_plot_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 160;
  localparam int H    = 120;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0, px_valid = '0, px_last = '0;
  logic [8*NREQ-1:0] px_x = '0;
  logic [7*NREQ-1:0] px_y = '0;
  logic [24*NREQ-1:0] px_colour = '0;
  logic [NREQ-1:0]   px_ready, grant;
  logic              clear_start = 1'b0;
  logic [23:0]       clear_colour = '0;
  logic              clear_busy;
  logic [7:0]        VGA_X;
  logic [6:0]        VGA_Y;
  logic [23:0]       VGA_COLOR;
  logic              plot;

  always #5 clk = ~clk;

  vga_plot_arbiter #(.NREQ(NREQ), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .CLOCK_50(clk), .resetn(rst), .req(req), .px_valid(px_valid),
    .px_last(px_last), .px_x(px_x), .px_y(px_y), .px_colour(px_colour),
    .px_ready(px_ready), .grant(grant), .clear_start(clear_start),
    .clear_colour(clear_colour), .clear_busy(clear_busy), .VGA_X(VGA_X),
    .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] c;
  } pix_t;

  typedef struct {
    int          r;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] c;
    bit          ep;
  } vec_t;

  pix_t        exp_q[$];
  pix_t        mon_e;
  int          n_cmp = 0, n_fail = 0, n_plot = 0;
  logic [7:0]  bx[16];
  logic [6:0]  by[16];
  logic [23:0] bc[16];
  bit          bp[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every plot must match the oldest expected pixel
  always @(negedge clk) begin
    if (!rst && plot === 1'b1) begin
      n_plot++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%h), expected no plot", VGA_X, VGA_Y, VGA_COLOR);
      end else begin
        mon_e = exp_q.pop_front();
        check("plot_pixel", {25'd0, VGA_X, VGA_Y, VGA_COLOR}, {25'd0, mon_e});
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_lane(input int r, input logic [7:0] x, input logic [6:0] y, input logic [23:0] c);
    px_x[r*8 +: 8]       = x;
    px_y[r*7 +: 7]       = y;
    px_colour[r*24 +: 24] = c;
  endtask

  task automatic set_beats(input int n, input int x0, input int y, input logic [23:0] c);
    for (int i = 0; i < n; i++) begin
      bx[i] = 8'(x0 + i);
      by[i] = 7'(y);
      bc[i] = c;
      bp[i] = ((x0 + i) < W) && (y < H);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (2) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push_clear(input logic [23:0] col);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back({8'(xx), 7'(yy), col});
  endtask

  // One burst from requester r using beats bx/by/bc; optional abort or clear pulse
  task automatic burst(input int r, input int n, input int abort_after, input int clr_at,
                       input logic [23:0] clr_col, input bit chk_lat);
    int cnt;
    req[r] = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (grant == '0 && cnt < 50);
    check("grant_owner", 64'(grant), 64'(1) << r);
    if (chk_lat) check("grant_latency", 64'(cnt), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) break;
      px_valid[r] = 1'b1;
      px_last[r]  = (i == n - 1);
      set_lane(r, bx[i], by[i], bc[i]);
      if (i == clr_at) begin
        clear_start  = 1'b1;
        clear_colour = clr_col;
      end
      check("px_ready", 64'(px_ready), 64'(1) << r);
      if (bp[i]) exp_q.push_back({bx[i], by[i], bc[i]});
      @(negedge clk);
      if (clear_start) begin
        clear_start = 1'b0;
        check("busy_after_start", 64'(clear_busy), 64'd1);
      end
    end
    if (abort_after >= 0 && abort_after < n) begin
      req[r]      = 1'b0;
      px_valid[r] = 1'b1;
      px_last[r]  = 1'b0;
      set_lane(r, 8'd77, 7'd9, 24'h123456);
      @(negedge clk);
      check("grant_after_abort", 64'(grant), 64'd0);
      px_valid[r] = 1'b0;
    end else begin
      px_valid[r] = 1'b0;
      px_last[r]  = 1'b0;
      req[r]      = 1'b0;
      check("grant_after_last", 64'(grant), 64'd0);
    end
  endtask

  vec_t vecs[8];
  int   exp_own[4];

  initial begin
    int cnt;
    int p0;
    bit prev_plot;
    bit fell;
    bit found;

    vecs[0] = '{0, 8'd0,   7'd0,   24'h111111, 1'b1};
    vecs[1] = '{2, 8'd159, 7'd119, 24'h222222, 1'b1};
    vecs[2] = '{1, 8'd160, 7'd0,   24'h333333, 1'b0};
    vecs[3] = '{0, 8'd0,   7'd120, 24'h444444, 1'b0};
    vecs[4] = '{2, 8'd255, 7'd127, 24'h555555, 1'b0};
    vecs[5] = '{1, 8'd159, 7'd0,   24'h666666, 1'b1};
    vecs[6] = '{0, 8'd80,  7'd60,  24'h777777, 1'b1};
    vecs[7] = '{2, 8'd0,   7'd119, 24'h888888, 1'b1};
    exp_own = '{0, 2, 0, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_px_ready", 64'(px_ready), 64'd0);
    check("rst_busy", 64'(clear_busy), 64'd0);
    check("rst_plot", 64'(plot), 64'd0);
    check("rst_vga", {25'd0, VGA_X, VGA_Y, VGA_COLOR}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single burst from requester 1
    set_beats(4, 10, 5, 24'hFF0000);
    burst(1, 4, -1, -1, 24'h0, 1'b1);
    drain("single_drain");

    // Contention between requesters 0 and 2 from pointer 0
    do_reset();
    req      = 3'b101;
    px_valid = 3'b111;
    for (int b = 0; b < 4; b++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (grant == '0 && cnt < 50);
      check("contention_owner", 64'(grant), 64'(1) << exp_own[b]);
      check("contention_gap", 64'(cnt), 64'd1);
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == exp_own[b]) set_lane(i, 8'(50 + 10*b + j), 7'(40 + i), 24'(i + 1));
          else                 set_lane(i, 8'(150 + i), 7'd100, 24'hABCDEF);
        end
        px_last = (j == 1) ? 3'b111 : 3'b000;
        exp_q.push_back({8'(50 + 10*b + j), 7'(40 + exp_own[b]), 24'(exp_own[b] + 1)});
        @(negedge clk);
      end
      check("contention_release", 64'(grant), 64'd0);
    end
    req = '0; px_valid = '0; px_last = '0;
    drain("contention_drain");

    // Clear requested mid-burst: burst finishes, then full green sweep
    set_beats(4, 60, 20, 24'h0000FF);
    burst(0, 4, -1, 1, 24'h00FF00, 1'b1);
    push_clear(24'h00FF00);
    @(negedge clk);
    p0 = n_plot;
    prev_plot = 1'b0;
    fell = 1'b0;
    cnt = 0;
    while (!fell && cnt < 20500) begin
      @(negedge clk);
      cnt++;
      if (cnt == 100) begin
        clear_start  = 1'b1;
        clear_colour = 24'hFF00FF;
      end else if (cnt == 101) begin
        clear_start = 1'b0;
      end
      if (clear_busy == 1'b0) begin
        fell = 1'b1;
        check("busy_fall_after_last_plot", 64'(prev_plot), 64'd1);
        check("no_plot_at_busy_fall", 64'(plot), 64'd0);
      end
      prev_plot = plot;
    end
    if (!fell) begin
      n_cmp++; n_fail++;
      $display("FAIL clear_timeout: got busy still high, expected busy to fall");
    end
    check("clear_plot_count", 64'(n_plot - p0), 64'(W * H));
    check("clear_drain", 64'(exp_q.size()), 64'd0);
    repeat (30) @(negedge clk);
    check("second_clear_ignored", 64'(clear_busy), 64'd0);

    // Out-of-range beat is consumed without plotting, next beat plots
    set_beats(2, 200, 3, 24'hC0FFEE);
    bx[1] = 8'd30; bp[1] = 1'b1;
    burst(1, 2, -1, -1, 24'h0, 1'b0);
    drain("oob_drain");

    // Table of single-beat bursts around the frame bounds
    for (int v = 0; v < 8; v++) begin
      bx[0] = vecs[v].x; by[0] = vecs[v].y; bc[0] = vecs[v].c; bp[0] = vecs[v].ep;
      burst(vecs[v].r, 1, -1, -1, 24'h0, 1'b1);
      drain("vec_drain");
    end

    // Abort after 2 of 5 beats, pointer moves past the aborted owner
    do_reset();
    req[2] = 1'b1;
    set_beats(5, 70, 30, 24'h0F0F0F);
    burst(0, 5, 2, -1, 24'h0, 1'b1);
    req[0] = 1'b1;
    set_beats(1, 90, 31, 24'hF0F0F0);
    burst(2, 1, -1, -1, 24'h0, 1'b1);
    req[0] = 1'b0;
    drain("abort_drain");

    // Reset in the middle of a clear
    clear_colour = 24'h0000FF;
    clear_start  = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    push_clear(24'h0000FF);
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (plot && VGA_X == 8'd40 && VGA_Y == 7'd7) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $display("FAIL reach_40_7: got pixel not seen, expected plot at (40,7)");
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_plot", 64'(plot), 64'd0);
    check("async_rst_grant", 64'(grant), 64'd0);
    check("async_rst_busy", 64'(clear_busy), 64'd0);
    check("async_rst_vga", {25'd0, VGA_X, VGA_Y, VGA_COLOR}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 64'(clear_busy), 64'd0);
    check("post_rst_grant", 64'(grant), 64'd0);
    set_beats(1, 5, 5, 24'hABABAB);
    burst(0, 1, -1, -1, 24'h0, 1'b1);
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
